// File: rtl/reg_file_pkg.sv
// Shared widths for the architectural register file and its commit bus.
package reg_file_pkg;
    localparam int REG_POS_WID = 5;
    localparam int ROB_POS_WID = 4;
    localparam int ROB_SIZE    = 1 << ROB_POS_WID;
    localparam int XLEN        = 32;

    typedef logic [REG_POS_WID-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]        xval_t;
endpackage

// File: rtl/reg_file_if.sv
// Commit/writeback bus from the reorder buffer into the register file.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int ROB_POS_W = ROB_POS_WID
);
    logic                 reg_write;
    reg_idx_t             reg_rd;
    xval_t                reg_val;
    logic [ROB_POS_W-1:0] commit_rob_pos;

    modport master (output reg_write, output reg_rd, output reg_val, output commit_rob_pos);
    modport slave  (input  reg_write, input  reg_rd, input  reg_val, input  commit_rob_pos);
endinterface

// File: rtl/reg_file_read_port.sv
// One operand read port: resolves stored val/busy/tag, optionally forwarding a
// same-cycle commit when REG_FILE_BYPASS_EN is defined.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int ROB_POS_W = ROB_POS_WID
) (
    input  reg_idx_t             idx,
    input  xval_t                st_val,
    input  logic                 st_busy,
    input  logic [ROB_POS_W-1:0] st_tag,
    input  logic                 cmt_en,
    input  reg_idx_t             cmt_rd,
    input  xval_t                cmt_val,
    input  logic [ROB_POS_W-1:0] cmt_tag,
    output xval_t                res_val,
    output logic                 res_busy,
    output logic [ROB_POS_W-1:0] res_tag
);

    always_comb begin
        res_val  = st_val;
        res_busy = st_busy;
        res_tag  = st_tag;
`ifdef REG_FILE_BYPASS_EN
        // Only the matching producer's commit retires the rename; a younger owner stays busy.
        if (cmt_en && cmt_rd == idx) begin
            res_val = cmt_val;
            if (st_busy && st_tag == cmt_tag)
                res_busy = 1'b0;
        end
`endif
        if (idx == '0) begin
            res_val  = '0;
            res_busy = 1'b0;
            res_tag  = '0;
        end
    end

`ifndef REG_FILE_BYPASS_EN
    logic unused_cmt;
    assign unused_cmt = ^{cmt_en, cmt_rd, cmt_val, cmt_tag};
`endif

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register busy/tag rename state.
// Optional same-cycle commit forwarding on reads: define REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_POS_W = ROB_POS_WID,
    parameter int NREG      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue,
    input  reg_idx_t             issue_rd,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    reg_file_if.slave            cmt,
    input  reg_idx_t             rs1,
    input  reg_idx_t             rs2,
    output xval_t                rs1_val,
    output xval_t                rs2_val,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_POS_W-1:0] rs1_rob_pos,
    output logic [ROB_POS_W-1:0] rs2_rob_pos
);

    xval_t                val  [NREG];
    logic [ROB_POS_W-1:0] tag  [NREG];
    logic [NREG-1:0]      busy;

    logic cmt_en;
    assign cmt_en = rdy && cmt.reg_write;

    // x0 is never written, so its reset value of zero is permanent.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
        end else if (rdy) begin
            if (cmt.reg_write && cmt.reg_rd != '0) begin
                val[cmt.reg_rd] <= cmt.reg_val;
                if (busy[cmt.reg_rd] && tag[cmt.reg_rd] == cmt.commit_rob_pos)
                    busy[cmt.reg_rd] <= 1'b0;
            end
            // Later assignments override the commit clear: issue owns rename state.
            if (rollback) begin
                busy <= '0;
            end else if (issue && issue_rd != '0) begin
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_rob_pos;
            end
        end
    end

    reg_file_read_port #(.ROB_POS_W(ROB_POS_W)) u_port1 (
        .idx      (rs1),
        .st_val   (val[rs1]),
        .st_busy  (busy[rs1]),
        .st_tag   (tag[rs1]),
        .cmt_en   (cmt_en),
        .cmt_rd   (cmt.reg_rd),
        .cmt_val  (cmt.reg_val),
        .cmt_tag  (cmt.commit_rob_pos),
        .res_val  (rs1_val),
        .res_busy (rs1_busy),
        .res_tag  (rs1_rob_pos)
    );

    reg_file_read_port #(.ROB_POS_W(ROB_POS_W)) u_port2 (
        .idx      (rs2),
        .st_val   (val[rs2]),
        .st_busy  (busy[rs2]),
        .st_tag   (tag[rs2]),
        .cmt_en   (cmt_en),
        .cmt_rd   (cmt.reg_rd),
        .cmt_val  (cmt.reg_val),
        .cmt_tag  (cmt.commit_rob_pos),
        .res_val  (rs2_val),
        .res_busy (rs2_busy),
        .res_tag  (rs2_rob_pos)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: driver pushes model-predicted read results,
// a negedge monitor pops and compares them against the read ports.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int TW = ROB_POS_WID;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b0;
    logic          rollback = 1'b0;
    logic          issue = 1'b0;
    reg_idx_t      issue_rd = '0;
    logic [TW-1:0] issue_rob_pos = '0;
    reg_idx_t      rs1 = '0, rs2 = '0;
    xval_t         rs1_val, rs2_val;
    logic          rs1_busy, rs2_busy;
    logic [TW-1:0] rs1_rob_pos, rs2_rob_pos;

    reg_file_if #(.ROB_POS_W(TW)) cmt_if ();

    reg_file #(.ROB_POS_W(TW), .NREG(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .rollback      (rollback),
        .issue         (issue),
        .issue_rd      (issue_rd),
        .issue_rob_pos (issue_rob_pos),
        .cmt           (cmt_if.slave),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_rob_pos   (rs1_rob_pos),
        .rs2_rob_pos   (rs2_rob_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   v1;
        logic          b1;
        logic [TW-1:0] t1;
        logic [31:0]   v2;
        logic          b2;
        logic [TW-1:0] t2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   drv_done = 1'b0;

    // Reference model: architectural register contents and rename map.
    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [TW-1:0] m_tag  [32];

    task automatic model_read(input int idx, input bit en, input int wrd, input logic [31:0] wval,
                              input logic [TW-1:0] wtag, output logic [31:0] v, output logic b,
                              output logic [TW-1:0] t);
        if (idx == 0) begin
            v = 0; b = 0; t = 0;
        end else begin
            v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef REG_FILE_BYPASS_EN
            if (en && wrd == idx) begin
                v = wval;
                if (m_busy[idx] && m_tag[idx] == wtag) b = 0;
            end
`endif
        end
    endtask

    task automatic model_apply(input bit r, input bit en, input bit rb, input bit iss, input int ird,
                               input logic [TW-1:0] itag, input bit wr, input int wrd,
                               input logic [31:0] wval, input logic [TW-1:0] wtag);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else if (en) begin
            if (wr && wrd != 0) begin
                m_val[wrd] = wval;
                if (m_busy[wrd] && m_tag[wrd] == wtag) m_busy[wrd] = 0;
            end
            if (rb) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (iss && ird != 0) begin
                m_busy[ird] = 1;
                m_tag[ird]  = itag;
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit rb, input bit iss, input int ird,
                        input int itag, input bit wr, input int wrd, input logic [31:0] wval,
                        input int wtag, input int r1, input int r2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rdy = en; rollback = rb;
        issue = iss; issue_rd = reg_idx_t'(ird); issue_rob_pos = TW'(itag);
        cmt_if.reg_write = wr; cmt_if.reg_rd = reg_idx_t'(wrd);
        cmt_if.reg_val = wval; cmt_if.commit_rob_pos = TW'(wtag);
        rs1 = reg_idx_t'(r1); rs2 = reg_idx_t'(r2);
        model_read(r1, en && wr, wrd, wval, TW'(wtag), e.v1, e.b1, e.t1);
        model_read(r2, en && wr, wrd, wval, TW'(wtag), e.v2, e.b2, e.t2);
        sb.push_back(e);
        model_apply(r, en, rb, iss, ird, TW'(itag), wr, wrd, wval, TW'(wtag));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: read ports are valid for the whole cycle, so every negedge with a pending entry is a sample.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rs1_val",     rs1_val,            e.v1);
            chk("rs1_busy",    32'(rs1_busy),      32'(e.b1));
            chk("rs1_rob_pos", 32'(rs1_rob_pos),   32'(e.t1));
            chk("rs2_val",     rs2_val,            e.v2);
            chk("rs2_busy",    32'(rs2_busy),      32'(e.b2));
            chk("rs2_rob_pos", 32'(rs2_rob_pos),   32'(e.t2));
        end
    end

    initial begin
        cmt_if.reg_write = 0; cmt_if.reg_rd = 0; cmt_if.reg_val = 0; cmt_if.commit_rob_pos = 0;
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
        repeat (2) @(posedge clk);

        //   rst rdy rb iss ird itag wr wrd wval          wtag rs1 rs2
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   5,  0);
        step(0,  1,  0, 0,  0,  0,   1, 0,  32'hDEAD,     0,   0,  5);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   0,  0);
        step(0,  1,  0, 1,  3,  2,   0, 0,  32'h0,        0,   3,  0);
        step(0,  1,  0, 0,  0,  0,   1, 3,  32'h1234,     2,   3,  0);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   3,  3);
        step(0,  1,  0, 1,  4,  1,   0, 0,  32'h0,        0,   4,  0);
        step(0,  1,  0, 1,  4,  5,   0, 0,  32'h0,        0,   4,  0);
        step(0,  1,  0, 0,  0,  0,   1, 4,  32'h7,        1,   4,  0);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   4,  4);
        step(0,  1,  0, 1,  6,  3,   0, 0,  32'h0,        0,   6,  0);
        step(0,  1,  0, 1,  6,  4,   1, 6,  32'h66,       3,   6,  0);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   6,  6);
        step(0,  1,  0, 1,  7,  1,   0, 0,  32'h0,        0,   0,  0);
        step(0,  1,  0, 1,  8,  2,   0, 0,  32'h0,        0,   7,  0);
        step(0,  1,  1, 1,  10, 3,   1, 9,  32'hAA,       0,   7,  8);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   7,  8);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   9,  10);
        step(0,  1,  0, 1,  11, 6,   0, 0,  32'h0,        0,   0,  0);
        step(0,  1,  0, 0,  0,  0,   1, 11, 32'h55,       6,   0,  11);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   11, 11);
        step(0,  1,  0, 1,  12, 6,   0, 0,  32'h0,        0,   0,  0);
        step(0,  0,  0, 1,  13, 2,   1, 12, 32'h77,       6,   12, 13);
        step(0,  0,  1, 0,  0,  0,   0, 0,  32'h0,        0,   12, 13);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   12, 13);
        step(0,  1,  0, 1,  14, 2,   1, 15, 32'hBEEF,     0,   0,  0);
        step(1,  0,  1, 1,  16, 3,   1, 17, 32'h1,        0,   14, 15);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   14, 15);
        step(0,  1,  0, 0,  0,  0,   0, 0,  32'h0,        0,   16, 17);

        for (int n = 0; n < 400; n++) begin
            int ird, wrd, wtag;
            ird  = $urandom_range(0, 15);
            wrd  = $urandom_range(0, 15);
            wtag = ($urandom_range(0, 1) == 1) ? int'(m_tag[wrd]) : int'($urandom_range(0, ROB_SIZE - 1));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1), ird, $urandom_range(0, ROB_SIZE - 1),
                 $urandom_range(0, 1), wrd, $urandom, wtag,
                 $urandom_range(0, 15), $urandom_range(0, 15));
        end

        @(posedge clk);
        #1;
        rdy = 0; issue = 0; cmt_if.reg_write = 0; rollback = 0;
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename state for the out-of-order core. Holds the 32 committed integer values plus, per register, a busy flag and the reorder-buffer tag of the youngest in-flight producer. Sits between the decoder, which reads operands and renames destinations at issue, and the reorder buffer, which writes committed results and broadcasts rollback. It is the receiving end of the reorder buffer's commit/writeback interface.

## Interface
Parameters:
- ROB_POS_W, 4, width of a reorder-buffer tag (ROB depth = 2^ROB_POS_W)
- NREG, 32, number of architectural registers (x0 hard-wired zero)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = hold all state
- rollback  in  1  misprediction flush from reorder buffer
- issue  in  1  decoder issues one instruction this cycle
- issue_rd  in  5  destination register of issued instruction (0 = none)
- issue_rob_pos  in  ROB_POS_W  tag allocated to issued instruction
- reg_write  in  1  commit writeback strobe from reorder buffer
- reg_rd  in  5  commit destination register
- reg_val  in  32  commit value
- commit_rob_pos  in  ROB_POS_W  tag of committing entry
- rs1, rs2  in  5 each  decoder source register indices
- rs1_val, rs2_val  out  32 each  committed value
- rs1_busy, rs2_busy  out  1 each  value pending in reorder buffer
- rs1_rob_pos, rs2_rob_pos  out  ROB_POS_W each  producer tag, meaningful only when busy

## Operation
- State per register r: val[r] (32), busy[r] (1), tag[r] (ROB_POS_W). Register 0: val, busy, tag constant 0; all writes and renames to x0 ignored.
- Commit (reg_write, reg_rd != 0): val[reg_rd] <= reg_val. If busy[reg_rd] and tag[reg_rd] == commit_rob_pos, busy[reg_rd] <= 0; otherwise busy/tag untouched (a younger producer owns the register).
- Issue (issue, issue_rd != 0, no rollback): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_pos.
- Same cycle commit and issue on same register: value written, busy = 1, tag = issue_rob_pos (issue wins on rename state).
- Rollback cycle: commit value write still applied (JALR commits and rolls back in one cycle); all busy cleared; issue ignored; tags left as is.
- Read ports combinational from stored state; an instruction issuing this cycle sees the mapping before its own rename, so rs == issue_rd yields the older producer.
- rdy low: no state change regardless of other inputs; outputs still track inputs combinationally.

## Timing
- Reset: all val = 0, busy = 0, tag = 0; outputs therefore 0 for every index.
- Write latency: commit visible on read ports the cycle after reg_write (without bypass).
- Rename latency: busy/tag visible the cycle after issue.
- No handshake; every input strobe consumed in its cycle.
- rst has priority over rdy and rollback; reset asserted mid-stream discards all pending rename state.

## Configuration
- REG_FILE_BYPASS_EN defined: read port forwards same-cycle commit. If reg_write, reg_rd == rs != 0, and tag[rs] == commit_rob_pos with busy[rs], outputs val = reg_val, busy = 0. If reg_write hits rs with tag mismatch, val = reg_val, busy/tag from state.
- Undefined: read ports show stored state only; decoder obtains the value through the reorder buffer ready/value lookup (one extra cycle of visibility only, functionally equivalent).

## Structure
- Shared definitions file holds REG_POS_WID, ROB_POS_WID, ROB_SIZE; reg_file uses them for port widths and default ROB_POS_W.
- One sub-module: reg_file_read_port (index in, stored val/busy/tag plus commit bus in, resolved val/busy/tag out, bypass logic under REG_FILE_BYPASS_EN), instantiated twice.

## Test plan
- Reset then read x5 -> val 0, busy 0, tag 0; reg_write x0 = 0xDEAD -> x0 still reads 0.
- Issue rd=3 tag 2; next cycle rs1=3 -> busy 1, tag 2; commit x3 = 0x1234 tag 2 -> next cycle val 0x1234, busy 0.
- Issue rd=4 tag 1, then rd=4 tag 5; commit tag 1 value 7 -> val 7, busy 1, tag 5.
- Commit x6 tag 3 and issue rd=6 tag 4 same cycle -> val = committed value, busy 1, tag 4.
- Busy x7, x8; rollback with reg_write x9 = 0xAA and issue rd=10 -> all busy 0, val[9] = 0xAA, x10 not renamed.
- With REG_FILE_BYPASS_EN: x11 busy tag 6, commit tag 6 value 0x55, rs2=11 same cycle -> rs2_val 0x55, rs2_busy 0; rdy low same stimulus -> state unchanged next cycle.
